// File: rtl/lut_mult_seq_ctrl.sv
// Sequential 4 x BW-bit unsigned multiplier built around one shared 4b x 2b LUT.
// B is consumed two bits per cycle, LSB digit first, with shift-accumulate of partials.

module lut_multiplier_2b (
    input  logic       reset,
    input  logic [3:0] a,
    input  logic [1:0] b,
    output logic [5:0] p
);
    always_comb begin
        p = '0;
        if (!reset) begin
            case (b)
                2'd0:    p = '0;
                2'd1:    p = {2'b00, a};
                2'd2:    p = {1'b0, a, 1'b0};
                default: p = {2'b00, a} + {1'b0, a, 1'b0};
            endcase
        end
    end
endmodule

module lut_mult_seq_ctrl #(
    parameter int BW = 8
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [3:0]                        a,
    input  logic [BW-1:0]                     b,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [BW+3:0]                     product,
    output logic                              busy,
    output logic [((BW/2 > 1) ? $clog2(BW/2) : 1)-1:0] digit
);
    localparam int ND = BW / 2;
    localparam int DW = (ND > 1) ? $clog2(ND) : 1;
    localparam int PW = BW + 4;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state_q, state_d;
    logic [3:0]     a_q, a_d;
    logic [BW-1:0]  b_q, b_d;
    logic [PW-1:0]  acc_q, acc_d;
    logic [PW-1:0]  product_q, product_d;
    logic [DW-1:0]  digit_q, digit_d;

    logic [1:0]     lut_b;
    logic [5:0]     lut_p;
    logic [PW-1:0]  partial;

    lut_multiplier_2b u_lut (
        .reset (1'b0),
        .a     (a_q),
        .b     (lut_b),
        .p     (lut_p)
    );

    // Constant-index mux keeps the digit select free of variable part-selects.
    always_comb begin
        lut_b = 2'b00;
        for (int i = 0; i < ND; i++) begin
            if (digit_q == DW'(i)) lut_b = b_q[2*i +: 2];
        end
    end

    assign partial = PW'(lut_p) << {digit_q, 1'b0};

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        product_d = product_q;
        digit_d   = digit_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    acc_d   = '0;
                    digit_d = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d = acc_q + partial;
                if (digit_q == DW'(ND - 1)) begin
                    product_d = acc_q + partial;
                    digit_d   = '0;
                    state_d   = DONE;
                end else begin
                    digit_d = digit_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            product_q <= '0;
            digit_q   <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            product_q <= product_d;
            digit_q   <= digit_d;
        end
    end

    // Handshake flags decode straight from the state flop, so nothing combinational reaches them.
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign product   = product_q;
    assign digit     = digit_q;
endmodule

// File: tb/tb_lut_mult_seq_ctrl.sv
// Randomized and directed bench for lut_mult_seq_ctrl against a plain a*b reference.

module tb_lut_mult_seq_ctrl;
    localparam int BW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [3:0]    a = '0;
    logic [BW-1:0] b = '0;
    logic          in_ready;
    logic          out_valid;
    logic          busy;
    logic [BW+3:0] product;
    logic [1:0]    digit;

    int n_checks = 0;
    int n_pass = 0;

    lut_mult_seq_ctrl #(.BW(BW)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy),
        .digit     (digit)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs === exp_v) n_pass++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
    endtask

    function automatic logic [31:0] ref_product(input logic [3:0] x, input logic [BW-1:0] y);
        return 32'(x) * 32'(y);
    endfunction

    // One full transaction: accept, ignored traffic while busy, optional sink stall, handshake.
    task automatic apply_stimulus(input logic [3:0] ta, input logic [BW-1:0] tb_v, input int stall);
        logic [31:0] expv;
        int lat;
        expv = ref_product(ta, tb_v);
        lat = 0;
        check_output("in_ready_idle", 32'(in_ready), 32'd1);
        a = ta;
        b = tb_v;
        in_valid = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        check_output("busy_run", 32'(busy), 32'd1);
        check_output("in_ready_run", 32'(in_ready), 32'd0);
        a = 4'd7;
        b = BW'($urandom);
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        in_valid = 1'b0;
        check_output("latency", 32'(lat), 32'(BW / 2));
        check_output("product", 32'(product), expv);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check_output("stall_valid", 32'(out_valid), 32'd1);
            check_output("stall_product", 32'(product), expv);
            check_output("stall_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_output("valid_drop", 32'(out_valid), 32'd0);
        check_output("back_idle", 32'(in_ready), 32'd1);
    endtask

    task automatic stream_test();
        logic [3:0]    sa[2];
        logic [BW-1:0] sb[2];
        logic [31:0]   got[$];
        int            got_cyc[$];
        int            idx;
        sa[0] = 4'd3; sb[0] = BW'(200);
        sa[1] = 4'd7; sb[1] = BW'(9);
        idx = 0;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (out_valid) begin
                got.push_back(32'(product));
                got_cyc.push_back(cyc);
            end
            if (in_ready && idx < 2) begin
                a = sa[idx];
                b = sb[idx];
                in_valid = 1'b1;
                idx++;
            end else if (!in_ready) begin
                a = 4'd7;
                b = BW'($urandom);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        check_output("stream_count", 32'(got.size()), 32'd2);
        if (got.size() >= 2) begin
            check_output("stream_p0", got[0], ref_product(sa[0], sb[0]));
            check_output("stream_p1", got[1], ref_product(sa[1], sb[1]));
            check_output("stream_spacing", 32'(got_cyc[1] - got_cyc[0]), 32'(BW / 2 + 2));
        end
        check_output("stream_idle", 32'(in_ready), 32'd1);
    endtask

    initial begin
        bit saw_valid;
        $display("[TB] start");
        repeat (2) @(negedge clk);
        check_output("rst_in_ready", 32'(in_ready), 32'd1);
        check_output("rst_out_valid", 32'(out_valid), 32'd0);
        check_output("rst_product", 32'(product), 32'd0);
        check_output("rst_busy", 32'(busy), 32'd0);
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_output("idle_stable", 32'({in_ready, out_valid, busy}), 32'b100);
        end

        apply_stimulus(4'hF, 8'hFF, 0);
        apply_stimulus(4'd5, 8'h00, 0);
        apply_stimulus(4'd0, 8'hAB, 1);
        apply_stimulus(4'd1, 8'h80, 0);
        apply_stimulus(4'd3, 8'd200, 3);
        stream_test();

        // Abort an operation at digit 2 with an asynchronous reset pulse.
        @(negedge clk);
        a = 4'd9;
        b = 8'hC3;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check_output("digit_before_abort", 32'(digit), 32'd2);
        reset = 1'b0;
        #1;
        check_output("abort_in_ready", 32'(in_ready), 32'd1);
        check_output("abort_out_valid", 32'(out_valid), 32'd0);
        check_output("abort_product", 32'(product), 32'd0);
        check_output("abort_busy", 32'(busy), 32'd0);
        check_output("abort_digit", 32'(digit), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        saw_valid = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) saw_valid = 1'b1;
        end
        check_output("no_valid_after_abort", 32'(saw_valid), 32'd0);
        apply_stimulus(4'd2, 8'd3, 0);

        for (int i = 0; i < 25; i++) begin
            apply_stimulus(4'($urandom), BW'($urandom), int'($urandom_range(0, 2)));
        end

        $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
